pc_next_unit: RTL and testbench

//  Delayed-PC register pair (dpc/pc) and next-address logic of the pipelined MIPS core.

---
 rtl/mips_pkg.sv | 40 ++++
 rtl/pc_target_calc.sv | 24 ++
 rtl/pc_next_unit.sv | 105 ++++++++++
 tb/tb_pc_next_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core PC path: widths, fixed addresses,
// PC-sequencer state and next-PC source selection.
package mips_pkg;

    localparam int unsigned N         = 32;
    localparam logic [31:0] SISR      = 32'h0000_0100;
    localparam logic [31:0] RESET_DPC = 32'h0000_0000;
    localparam logic [31:0] RESET_PC  = 32'h0000_0004;

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } pc_state_e;

    typedef enum logic [1:0] {
        SEQ = 2'd0,
        BR  = 2'd1,
        J   = 2'd2,
        JR  = 2'd3
    } npc_sel_e;

    // Class inputs are one-hot; if several are set, jr beats jump beats branch.
    function automatic npc_sel_e npc_select(
        input logic dec_valid,
        input logic is_jr,
        input logic is_jump,
        input logic is_branch,
        input logic bcres
    );
        npc_sel_e sel;
        sel = SEQ;
        if (dec_valid) begin
            if (is_jr)                    sel = JR;
            else if (is_jump)             sel = J;
            else if (is_branch && bcres)  sel = BR;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational control-transfer targets relative to the delay-slot base dpc+4.
module pc_target_calc
    import mips_pkg::*;
#(
    parameter int unsigned N = mips_pkg::N
) (
    input  logic [N-1:0] dpc,
    input  logic [15:0]  imm16,
    input  logic [25:0]  iindex,
    output logic [N-1:0] btarget,
    output logic [N-1:0] jtarget,
    output logic [N-1:0] link_addr
);

    logic [N-1:0] base;
    logic [N-1:0] boffset;

    assign base      = dpc + N'(4);
    assign boffset   = {{(N-18){imm16[15]}}, imm16, 2'b00};
    assign btarget   = base + boffset;
    assign jtarget   = {base[N-1:28], iindex, 2'b00};
    assign link_addr = base;

endmodule

// File: rtl/pc_next_unit.sv
// Delayed-PC register pair and next fetch address selection, with delayed
// branch semantics and jisr/eret redirects from the interrupt stage.
module pc_next_unit
    import mips_pkg::*;
#(
    parameter int unsigned    N        = mips_pkg::N,
    parameter logic [N-1:0]   SISR_ADR = N'(mips_pkg::SISR)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ue,
    input  logic          dec_valid,
    input  logic          is_branch,
    input  logic          is_jump,
    input  logic          is_jr,
    input  logic          bcres,
    input  logic [15:0]   imm16,
    input  logic [25:0]   iindex,
    input  logic [N-1:0]  rs_val,
    input  logic          jisr,
    input  logic          eret,
    input  logic [N-1:0]  epc,
    input  logic [N-1:0]  edpc,
    output logic [N-1:0]  fetch_addr,
    output logic          fetch_valid,
    output logic [N-1:0]  pc_q,
    output logic [N-1:0]  link_addr,
    output logic          taken,
    output logic          misalign
);

    pc_state_e    state_q, state_d;
    logic [N-1:0] dpc_q, dpc_d;
    logic [N-1:0] pc_d;
    logic         misalign_q, misalign_d;

    logic [N-1:0] btarget;
    logic [N-1:0] jtarget;
    logic [N-1:0] nextpc;
    npc_sel_e     sel;

    pc_target_calc #(.N(N)) u_target (
        .dpc       (dpc_q),
        .imm16     (imm16),
        .iindex    (iindex),
        .btarget   (btarget),
        .jtarget   (jtarget),
        .link_addr (link_addr)
    );

    assign sel = npc_select(dec_valid, is_jr, is_jump, is_branch, bcres);

    always_comb begin
        nextpc = pc_q + N'(4);
        unique case (sel)
            JR:      nextpc = rs_val;
            J:       nextpc = jtarget;
            BR:      nextpc = btarget;
            default: nextpc = pc_q + N'(4);
        endcase
    end

    assign taken = dec_valid & (is_jr | is_jump | (is_branch & bcres));

    // Redirects win over a regular advance and also act while still in BOOT.
    always_comb begin
        state_d    = RUN;
        dpc_d      = dpc_q;
        pc_d       = pc_q;
        misalign_d = misalign_q;
        if (jisr) begin
            dpc_d      = SISR_ADR;
            pc_d       = SISR_ADR + N'(4);
            misalign_d = 1'b0;
        end else if (eret) begin
            dpc_d = epc;
            pc_d  = edpc;
        end else if ((state_q == RUN) && ue) begin
            dpc_d = pc_q;
            pc_d  = nextpc;
            if (dec_valid && is_jr && (|rs_val[1:0])) begin
                misalign_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= BOOT;
            dpc_q      <= N'(RESET_DPC);
            pc_q       <= N'(RESET_PC);
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dpc_q      <= dpc_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign fetch_addr  = dpc_q;
    assign fetch_valid = (state_q == RUN);
    assign misalign    = misalign_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Randomized and directed check of pc_next_unit against a behavioural model.
module tb_pc_next_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ue = 1'b0, dec_valid = 1'b0, is_branch = 1'b0, is_jump = 1'b0, is_jr = 1'b0, bcres = 1'b0;
    logic [15:0] imm16 = '0;
    logic [25:0] iindex = '0;
    logic [31:0] rs_val = '0, epc = '0, edpc = '0;
    logic        jisr = 1'b0, eret = 1'b0;
    logic [31:0] fetch_addr, pc_q, link_addr;
    logic        fetch_valid, taken, misalign;

    int errors = 0;
    int checks = 0;

    pc_next_unit dut (
        .clk(clk), .reset(reset), .ue(ue), .dec_valid(dec_valid),
        .is_branch(is_branch), .is_jump(is_jump), .is_jr(is_jr), .bcres(bcres),
        .imm16(imm16), .iindex(iindex), .rs_val(rs_val), .jisr(jisr), .eret(eret),
        .epc(epc), .edpc(edpc), .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
        .pc_q(pc_q), .link_addr(link_addr), .taken(taken), .misalign(misalign)
    );

    always #5 clk = ~clk;

    // Behavioural model: architectural dpc/pc pair, running flag, sticky misalign flag.
    logic [31:0] m_dpc, m_pc;
    logic        m_run, m_mis;

    function automatic logic [31:0] model_next(input logic [31:0] d, input logic [31:0] p);
        logic [31:0] slot;
        int signed   off;
        slot = d + 32'd4;
        off  = int'($signed(imm16)) * 4;
        if (dec_valid && is_jr)                return rs_val;
        if (dec_valid && is_jump)              return (slot & 32'hF000_0000) | (32'(iindex) * 4);
        if (dec_valid && is_branch && bcres)   return slot + 32'(off);
        return p + 32'd4;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_dpc <= 32'h0; m_pc <= 32'h4; m_run <= 1'b0; m_mis <= 1'b0;
        end else begin
            m_run <= 1'b1;
            if (jisr) begin
                m_dpc <= 32'h100; m_pc <= 32'h104; m_mis <= 1'b0;
            end else if (eret) begin
                m_dpc <= epc; m_pc <= edpc;
            end else if (m_run && ue) begin
                m_dpc <= m_pc;
                m_pc  <= model_next(m_dpc, m_pc);
                if (dec_valid && is_jr && (rs_val % 4 != 0)) m_mis <= 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("fetch_addr", fetch_addr, m_dpc);
        chk("pc_q", pc_q, m_pc);
        chk("fetch_valid", 32'(fetch_valid), 32'(m_run));
        chk("link_addr", link_addr, m_dpc + 32'd4);
        chk("misalign", 32'(misalign), 32'(m_mis));
        chk("taken", 32'(taken), 32'(dec_valid && (is_jr || is_jump || (is_branch && bcres))));
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic clear_ctrl();
        dec_valid = 1'b0; is_branch = 1'b0; is_jump = 1'b0; is_jr = 1'b0; bcres = 1'b0;
        jisr = 1'b0; eret = 1'b0;
    endtask

    task automatic load(input logic [31:0] d, input logic [31:0] p);
        clear_ctrl();
        eret = 1'b1; epc = d; edpc = p;
        step();
        eret = 1'b0;
    endtask

    initial begin
        // 1: reset, boot cycle, sequential fetch
        repeat (3) @(posedge clk);
        #1;
        chk("rst_fetch_valid", 32'(fetch_valid), 32'h0);
        chk("rst_dpc", fetch_addr, 32'h0);
        chk("rst_pc", pc_q, 32'h4);
        chk("rst_misalign", 32'(misalign), 32'h0);
        reset = 1'b0; ue = 1'b1;
        @(negedge clk);
        chk("boot_fetch_valid", 32'(fetch_valid), 32'h0);
        step();
        chk("run_fetch_valid", 32'(fetch_valid), 32'h1);
        chk("boot_hold_dpc", fetch_addr, 32'h0);
        step(); chk("seq_4", fetch_addr, 32'h4);
        step(); chk("seq_8", fetch_addr, 32'h8);
        step(); chk("seq_12", fetch_addr, 32'hC);

        // 2: taken and not-taken branch with delay slot
        load(32'h40, 32'h44);
        dec_valid = 1'b1; is_branch = 1'b1; bcres = 1'b1; imm16 = 16'h0003;
        step();
        chk("br_slot_dpc", fetch_addr, 32'h44);
        chk("br_taken_pc", pc_q, 32'h50);
        load(32'h40, 32'h44);
        dec_valid = 1'b1; is_branch = 1'b1; bcres = 1'b0;
        step();
        chk("br_nt_pc", pc_q, 32'h48);

        // 3: backward branch and region-relative jump
        load(32'h40, 32'h44);
        dec_valid = 1'b1; is_branch = 1'b1; bcres = 1'b1; imm16 = 16'hFFFF;
        step();
        chk("br_back_pc", pc_q, 32'h40);
        load(32'hF000_0000, 32'hF000_0004);
        dec_valid = 1'b1; is_jump = 1'b1; iindex = 26'h0000010;
        step();
        chk("j_pc", pc_q, 32'hF000_0040);

        // 4: misaligned jr is sticky until jisr
        clear_ctrl();
        dec_valid = 1'b1; is_jr = 1'b1; rs_val = 32'h0000_1002;
        step();
        chk("jr_pc", pc_q, 32'h1002);
        chk("jr_misalign", 32'(misalign), 32'h1);
        clear_ctrl();
        step();
        chk("misalign_sticky", 32'(misalign), 32'h1);
        jisr = 1'b1;
        step();
        chk("jisr_dpc", fetch_addr, 32'h100);
        chk("jisr_pc", pc_q, 32'h104);
        chk("jisr_misalign", 32'(misalign), 32'h0);

        // 5: stall holds with branch asserted; jisr beats eret
        clear_ctrl();
        ue = 1'b0; dec_valid = 1'b1; is_branch = 1'b1; bcres = 1'b1; imm16 = 16'h0010;
        repeat (5) step();
        chk("stall_dpc", fetch_addr, 32'h100);
        chk("stall_pc", pc_q, 32'h104);
        clear_ctrl();
        load(32'h500, 32'h504);
        jisr = 1'b1; eret = 1'b1; epc = 32'h200; edpc = 32'h300;
        step();
        chk("jisr_over_eret", fetch_addr, 32'h100);

        // 6: eret while stalled, then asynchronous reset mid-cycle
        clear_ctrl();
        eret = 1'b1; epc = 32'h200; edpc = 32'h300;
        step();
        chk("eret_dpc", fetch_addr, 32'h200);
        chk("eret_pc", pc_q, 32'h300);
        clear_ctrl();
        #2 reset = 1'b1;
        #1;
        chk("async_dpc", fetch_addr, 32'h0);
        chk("async_pc", pc_q, 32'h4);
        chk("async_valid", 32'(fetch_valid), 32'h0);
        step();
        reset = 1'b0;

        // Randomized traffic checked every cycle by the compare process
        for (int i = 0; i < 600; i++) begin
            step();
            clear_ctrl();
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 127) == 0) reset = 1'b1;
            ue        = ($urandom_range(0, 3) != 0);
            dec_valid = ($urandom_range(0, 4) != 0);
            case ($urandom_range(0, 3))
                0: is_branch = 1'b1;
                1: is_jump   = 1'b1;
                2: is_jr     = 1'b1;
                default: ;
            endcase
            bcres  = 1'($urandom);
            imm16  = 16'($urandom);
            iindex = 26'($urandom);
            rs_val = $urandom;
            if ($urandom_range(0, 3) != 0) rs_val[1:0] = 2'b00;
            jisr = ($urandom_range(0, 31) == 0);
            eret = ($urandom_range(0, 23) == 0);
            epc  = $urandom;
            edpc = $urandom;
        end
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
